pc_branch_sequencer: RTL and testbench

Per-core branch/PC sequencer for the TinyGPU execute and update stages. It holds one 3-bit NZP flag register per thread and walks the active threads serially through a single shared flag-match evaluation (taken = |(thread NZP & instruction nzp)). It writes CMP results into the per-thread NZP registers and resolves BRnzp into one converged next PC, raising a divergence flag when active threads disagree. The core scheduler starts it with a pulse and waits for Done before advancing to FETCH.

---
 rtl/pc_branch_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_branch_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_sequencer.sv
// Per-core branch/PC sequencer: serially scans active threads through one shared
// NZP match, writes CMP results and resolves a converged next PC with divergence.
module pc_branch_sequencer #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [THREADS-1:0]     ThreadMask,
  input  logic [PC_BITS-1:0]     CurrentPC,
  input  logic                   NZPWriteEnable,
  input  logic [3*THREADS-1:0]   NZPIn,
  input  logic                   PCMux,
  input  logic [2:0]             BranchNZP,
  input  logic [PC_BITS-1:0]     Immediate,
  output logic                   Busy,
  output logic                   Done,
  output logic [PC_BITS-1:0]     NextPC,
  output logic                   Diverged,
  output logic [3*THREADS-1:0]   NZPState
);

  localparam int IW = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam logic [IW-1:0] LAST = IW'(THREADS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
  state_t state, state_nx;

  logic [IW-1:0]          idx;
  logic [THREADS-1:0]     l_mask;
  logic [PC_BITS-1:0]     l_pc;
  logic                   l_we;
  logic [3*THREADS-1:0]   l_nzpin;
  logic                   l_pcmux;
  logic [2:0]             l_bnzp;
  logic [PC_BITS-1:0]     l_imm;
  logic [2:0]             nzp [THREADS];

  logic [PC_BITS-1:0]     ref_pc, pc_inc, cand;
  logic                   seen, div, active, taken, mismatch;

  // Shared per-step evaluation for the thread currently addressed by idx.
  always_comb begin
    pc_inc   = l_pc + PC_BITS'(1);
    active   = l_mask[idx];
    taken    = |(nzp[idx] & l_bnzp);
    cand     = pc_inc;
    if (!l_we && l_pcmux && taken) cand = l_imm;
    mismatch = active && seen && (cand != ref_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE:   if (Start) state_nx = SCAN;
      SCAN: begin
        Busy = 1'b1;
        if (idx == LAST) state_nx = FINISH;
      end
      FINISH: begin
        Busy     = 1'b1;
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are committed on the last scan step so they are already valid while Done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < THREADS; i++) nzp[i] <= '0;
      NextPC   <= '0;
      Diverged <= 1'b0;
      idx      <= '0;
      seen     <= 1'b0;
      div      <= 1'b0;
      ref_pc   <= '0;
      l_mask   <= '0;
      l_pc     <= '0;
      l_we     <= 1'b0;
      l_nzpin  <= '0;
      l_pcmux  <= 1'b0;
      l_bnzp   <= '0;
      l_imm    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            l_mask  <= ThreadMask;
            l_pc    <= CurrentPC;
            l_we    <= NZPWriteEnable;
            l_nzpin <= NZPIn;
            l_pcmux <= PCMux;
            l_bnzp  <= BranchNZP;
            l_imm   <= Immediate;
            idx     <= '0;
            seen    <= 1'b0;
            div     <= 1'b0;
            // Default reference covers the no-active-thread case.
            ref_pc  <= CurrentPC + PC_BITS'(1);
          end
        end
        SCAN: begin
          if (active) begin
            if (l_we) nzp[idx] <= l_nzpin[3*idx +: 3];
            if (!seen) begin
              ref_pc <= cand;
              seen   <= 1'b1;
            end
            if (mismatch) div <= 1'b1;
          end
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            NextPC   <= (active && !seen) ? cand : ref_pc;
            Diverged <= div | mismatch;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    NZPState = '0;
    for (int unsigned i = 0; i < THREADS; i++) NZPState[3*i +: 3] = nzp[i];
  end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Self-checking bench for pc_branch_sequencer: directed table, corner sequences
// and randomized operations checked against a thread-list reference model.
module tb_pc_branch_sequencer;

  localparam int THREADS = 4;
  localparam int PC_BITS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  ThreadMask;
  logic [7:0]  CurrentPC;
  logic        NZPWriteEnable;
  logic [11:0] NZPIn;
  logic        PCMux;
  logic [2:0]  BranchNZP;
  logic [7:0]  Immediate;
  logic        Busy, Done, Diverged;
  logic [7:0]  NextPC;
  logic [11:0] NZPState;

  pc_branch_sequencer #(.THREADS(THREADS), .PC_BITS(PC_BITS)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ThreadMask(ThreadMask),
    .CurrentPC(CurrentPC), .NZPWriteEnable(NZPWriteEnable), .NZPIn(NZPIn),
    .PCMux(PCMux), .BranchNZP(BranchNZP), .Immediate(Immediate),
    .Busy(Busy), .Done(Done), .NextPC(NextPC), .Diverged(Diverged),
    .NZPState(NZPState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: per-thread flags plus a list of resolved candidate PCs.
  logic [2:0] m_nzp [4];

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_nzp[t] = 3'b000;
  endtask

  task automatic model_op(input logic [3:0] mask, input logic [7:0] pc, input logic we,
                          input logic [11:0] nzpin, input logic pcmux, input logic [2:0] b,
                          input logic [7:0] imm, output logic [7:0] epc, output logic ediv);
    logic [7:0] cands[$];
    logic [7:0] c;
    logic [7:0] seq;
    seq = pc + 8'd1;
    for (int t = 0; t < 4; t++) begin
      if (mask[t]) begin
        if (we) begin
          m_nzp[t] = nzpin[3*t +: 3];
          c = seq;
        end else if (pcmux) begin
          c = ((m_nzp[t] & b) != 3'b000) ? imm : seq;
        end else begin
          c = seq;
        end
        cands.push_back(c);
      end
    end
    epc  = (cands.size() == 0) ? seq : cands[0];
    ediv = 1'b0;
    foreach (cands[k]) if (cands[k] != epc) ediv = 1'b1;
  endtask

  function automatic logic [11:0] model_state();
    logic [11:0] s;
    for (int t = 0; t < 4; t++) s[3*t +: 3] = m_nzp[t];
    return s;
  endfunction

  // Starts one operation in the next cycle; returns at the negedge Done is seen.
  task automatic do_op(input logic [3:0] mask, input logic [7:0] pc, input logic we,
                       input logic [11:0] nzpin, input logic pcmux, input logic [2:0] b,
                       input logic [7:0] imm, output int lat, output int busy_cnt);
    bit got;
    @(negedge clk);
    ThreadMask = mask; CurrentPC = pc; NZPWriteEnable = we; NZPIn = nzpin;
    PCMux = pcmux; BranchNZP = b; Immediate = imm; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    ThreadMask = 4'($urandom); CurrentPC = 8'($urandom); NZPWriteEnable = 1'($urandom);
    NZPIn = 12'($urandom); PCMux = 1'($urandom); BranchNZP = 3'($urandom);
    Immediate = 8'($urandom);
    lat = 99; busy_cnt = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        got = 1;
        lat = k;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  pc;
    logic        we;
    logic [11:0] nzpin;
    logic        pcmux;
    logic [2:0]  b;
    logic [7:0]  imm;
    logic [7:0]  exp_pc;
    logic        exp_div;
    logic [11:0] exp_nzp;
  } vec_t;

  vec_t vt [7];

  initial begin
    int lat, bc, dones;
    logic [7:0] epc;
    logic       ediv;

    vt[0] = '{4'b1111, 8'h05, 1'b1, 12'h88A, 1'b0, 3'b000, 8'h00, 8'h06, 1'b0, 12'h88A};
    vt[1] = '{4'b0101, 8'h10, 1'b0, 12'h000, 1'b1, 3'b010, 8'h20, 8'h20, 1'b0, 12'h88A};
    vt[2] = '{4'b1111, 8'h10, 1'b0, 12'h000, 1'b1, 3'b010, 8'h20, 8'h20, 1'b1, 12'h88A};
    vt[3] = '{4'b0000, 8'hFF, 1'b0, 12'hFFF, 1'b0, 3'b111, 8'h33, 8'h00, 1'b0, 12'h88A};
    vt[4] = '{4'b0011, 8'h30, 1'b1, 12'h63E, 1'b1, 3'b111, 8'h77, 8'h31, 1'b0, 12'h8BE};
    vt[5] = '{4'b1010, 8'h40, 1'b0, 12'h000, 1'b1, 3'b100, 8'h50, 8'h50, 1'b0, 12'h8BE};
    vt[6] = '{4'b1000, 8'h40, 1'b0, 12'h000, 1'b1, 3'b001, 8'h50, 8'h41, 1'b0, 12'h8BE};

    reset = 1'b1; Start = 1'b0; ThreadMask = '0; CurrentPC = '0; NZPWriteEnable = 1'b0;
    NZPIn = '0; PCMux = 1'b0; BranchNZP = '0; Immediate = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_nextpc", 32'(NextPC), 32'd0);
    check("reset_div", 32'(Diverged), 32'd0);
    check("reset_nzp", 32'(NZPState), 32'd0);

    foreach (vt[i]) begin
      model_op(vt[i].mask, vt[i].pc, vt[i].we, vt[i].nzpin, vt[i].pcmux, vt[i].b, vt[i].imm, epc, ediv);
      do_op(vt[i].mask, vt[i].pc, vt[i].we, vt[i].nzpin, vt[i].pcmux, vt[i].b, vt[i].imm, lat, bc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_busy", i), 32'(bc), 32'd5);
      check($sformatf("vec%0d_nextpc", i), 32'(NextPC), 32'(vt[i].exp_pc));
      check($sformatf("vec%0d_div", i), 32'(Diverged), 32'(vt[i].exp_div));
      @(negedge clk);
      check($sformatf("vec%0d_nzp", i), 32'(NZPState), 32'(vt[i].exp_nzp));
      check($sformatf("vec%0d_hold_pc", i), 32'(NextPC), 32'(vt[i].exp_pc));
    end

    // Reset in the middle of a CMP scan: no Done, all flags cleared.
    @(negedge clk);
    ThreadMask = 4'b1111; CurrentPC = 8'h55; NZPWriteEnable = 1'b1; NZPIn = 12'hFFF;
    PCMux = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (Done) dones++;
      @(negedge clk);
    end
    check("abort_dones", 32'(dones), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_nzp", 32'(NZPState), 32'd0);
    check("abort_nextpc", 32'(NextPC), 32'd0);
    check("abort_div", 32'(Diverged), 32'd0);
    do_op(4'b1111, 8'h60, 1'b0, 12'h000, 1'b1, 3'b111, 8'h99, lat, bc);
    check("abort_br_latency", 32'(lat), 32'd5);
    check("abort_br_nextpc", 32'(NextPC), 32'h61);
    check("abort_br_div", 32'(Diverged), 32'd0);

    // Start pulsed again mid-scan must be ignored.
    @(negedge clk);
    ThreadMask = 4'b1111; CurrentPC = 8'h70; NZPWriteEnable = 1'b0; PCMux = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    dones = 0; bc = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) Start = 1'b1;
      if (k == 3) begin
        Start = 1'b0;
        CurrentPC = 8'hA0;
      end
      if (Done) begin
        dones++;
        check("midstart_nextpc", 32'(NextPC), 32'h71);
      end
      if (Busy) bc++;
      @(negedge clk);
    end
    check("midstart_dones", 32'(dones), 32'd1);
    check("midstart_busy", 32'(bc), 32'd5);

    // Randomized back-to-back operations against the model.
    for (int r = 0; r < 40; r++) begin
      logic [3:0]  mask;
      logic [7:0]  pc, imm;
      logic        we, pm;
      logic [11:0] nin;
      logic [2:0]  b;
      mask = 4'($urandom); pc = 8'($urandom); imm = 8'($urandom);
      we = ($urandom_range(0, 2) == 0); pm = 1'($urandom);
      nin = 12'($urandom); b = 3'($urandom);
      if (r % 10 == 0) pc = 8'hFF;
      model_op(mask, pc, we, nin, pm, b, imm, epc, ediv);
      do_op(mask, pc, we, nin, pm, b, imm, lat, bc);
      check($sformatf("rnd%0d_latency", r), 32'(lat), 32'd5);
      check($sformatf("rnd%0d_nextpc", r), 32'(NextPC), 32'(epc));
      check($sformatf("rnd%0d_div", r), 32'(Diverged), 32'(ediv));
      check($sformatf("rnd%0d_nzp", r), 32'(NZPState), 32'(model_state()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
